// File: rtl/booth_wallace_cla_mult.sv
// Signed WIDTH x WIDTH multiplier: radix-4 Booth partial products, Wallace
// carry-save reduction, 4-bit-group carry-lookahead final adder, one register stage.
module booth_wallace_cla_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW    = 2 * WIDTH;
  localparam int NPP   = WIDTH / 2;
  localparam int NROWS = NPP + 1;  // Booth rows plus the negation-correction row

  function automatic int csa_rows(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = NROWS;
    for (int k = 0; k < lvl; k++) n = csa_rows(n);
    return n;
  endfunction

  function automatic int tree_levels(input int n);
    int lvl;
    int r;
    lvl = 0;
    r   = n;
    while (r > 2) begin
      r = csa_rows(r);
      lvl++;
    end
    return lvl;
  endfunction

  localparam int NLVL = tree_levels(NROWS);

  logic [PW-1:0] pp_rows [NROWS];
  logic [PW-1:0] corr_row;
  logic [PW-1:0] product_d, product_q;
  logic          out_valid_d, out_valid_q;

  // Booth recoding: each digit selects 0, +-A or +-2A; negatives are one's
  // complemented here and the missing +1 goes into the correction row.
  always_comb begin : booth_pp
    logic [WIDTH:0]   b_ext;
    logic [2:0]       trip;
    logic [WIDTH+1:0] a1, a2, mag, pp;
    logic             neg;
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    b_ext    = {multiplier, 1'b0};
    a1       = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    a2       = {multiplicand[WIDTH-1], multiplicand, 1'b0};
    trip     = '0;
    mag      = '0;
    pp       = '0;
    neg      = 1'b0;
    corr_row = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: begin mag = a1; neg = 1'b0; end
        3'b011:         begin mag = a2; neg = 1'b0; end
        3'b100:         begin mag = a2; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a1; neg = 1'b1; end
        default:        begin mag = '0; neg = 1'b0; end
      endcase
      pp            = neg ? ~mag : mag;
      pp_rows[i]    = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp} << (2 * i);
      corr_row[2*i] = neg;
    end
    pp_rows[NPP] = corr_row;
  end

  // Wallace reduction to two rows, then the carry-lookahead adder.
  always_comb begin : tree_cla
    logic [PW-1:0] tree [NLVL+1][NROWS];
    logic [PW-1:0] x, y, a, b, c, sum;
    logic [3:0]    g, p, cc;
    logic          cin;
    int            n;

    tree = '{default: '0};
    for (int r = 0; r < NROWS; r++) tree[0][r] = pp_rows[r];

    for (int l = 0; l < NLVL; l++) begin
      n = rows_at(l);
      for (int j = 0; j < NROWS / 3; j++) begin
        if (3 * j + 2 < n) begin
          a = tree[l][3*j];
          b = tree[l][3*j+1];
          c = tree[l][3*j+2];
          tree[l+1][2*j]   = a ^ b ^ c;
          tree[l+1][2*j+1] = ((a & b) | (a & c) | (b & c)) << 1;
        end
      end
      // Rows that do not fill a 3:2 compressor pass straight to the next level.
      for (int k = 0; k < 2; k++) begin
        if (k < n % 3) tree[l+1][2*(n/3)+k] = tree[l][3*(n/3)+k];
      end
    end

    x   = tree[NLVL][0];
    y   = tree[NLVL][1];
    sum = '0;
    cin = 1'b0;
    for (int k = 0; k < PW / 4; k++) begin
      g     = x[4*k +: 4] & y[4*k +: 4];
      p     = x[4*k +: 4] ^ y[4*k +: 4];
      cc[0] = cin;
      cc[1] = g[0] | (p[0] & cin);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      sum[4*k +: 4] = p ^ cc;
      cin   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | ((&p) & cin);
    end

    product_d   = in_valid ? sum : product_q;
    out_valid_d = in_valid;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign product   = product_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_wallace_cla_mult.sv
// Self-checking bench for booth_wallace_cla_mult: directed corner products,
// async reset, hold behaviour and random pairs against an arithmetic model.
module tb_booth_wallace_cla_mult;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic [2*W-1:0] product;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2*W-1:0] exp_prod  = '0;
  logic           exp_valid = 1'b0;

  booth_wallace_cla_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint full;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    full = sa * sb;
    return full[31:0];
  endfunction

  // Applies one cycle of stimulus from a negedge, checks just after the posedge.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid     = v;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    if (v) exp_prod = ref_mult(a, b);
    exp_valid = v;
    check("product", product, exp_prod);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    @(negedge clk);
  endtask

  logic [W-1:0] corners [4];
  logic [31:0]  held;

  initial begin
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    check("reset_product", product, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 16'd3, 16'd2);
    check("dir_3x2", product, 32'h0000_0006);
    drive(1'b1, 16'hFFFD, 16'hFFFE);
    check("dir_m3xm2", product, 32'h0000_0006);
    drive(1'b1, 16'hFFFD, 16'd2);
    check("dir_m3x2", product, 32'hFFFF_FFFA);
    drive(1'b1, 16'h7FFF, 16'h7FFF);
    check("dir_max_max", product, 32'h3FFF_0001);
    drive(1'b1, 16'h8000, 16'h8000);
    check("dir_min_min", product, 32'h4000_0000);
    drive(1'b1, 16'h8000, 16'h7FFF);
    check("dir_min_max", product, 32'hC000_8000);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        drive(1'b1, corners[i], corners[j]);

    // Hold: product must keep its last loaded value while in_valid is low.
    drive(1'b1, 16'h1234, 16'hFEDC);
    held = ref_mult(16'h1234, 16'hFEDC);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'($urandom), 16'($urandom));
      check("hold_value", product, held);
    end

    // Asynchronous reset in the middle of a cycle, with traffic still offered.
    drive(1'b1, 16'h0101, 16'h0202);
    in_valid     = 1'b1;
    multiplicand = 16'h5555;
    multiplier   = 16'h3333;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_product", product, 32'h0);
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_product", product, 32'h0);
    check("rst_held_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_prod  = '0;
    exp_valid = 1'b0;
    drive(1'b0, 16'h7777, 16'h7777);

    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
